mod_voice_scheduler: RTL and testbench
======================================

# mod_voice_scheduler

Time-multiplexes a single shared `mod_synth` core across `NUM_VOICES` polyphonic voices. On every audio sample tick it walks the enabled voices in index order, triggers the synth once per voice using the trigger/ready handshake, and accumulates each returned sample. It then emits one saturated mixed sample per tick. It sits between the key/voice-allocation logic and the shared `mod_synth` instance, and replaces per-voice synth drivers.

## Interface
- `NUM_VOICES`, 4, number of voices (1..16)
- `SAMPLE_DIV`, 1042, `i_clk` cycles per sample tick
- `i_clk`  in  1  system clock
- `i_rst`  in  1  reset; one clock, asynchronous, active-high
- `i_voice_freq`  in  `NUM_VOICES`×32  per-voice frequency, packed, voice 0 in LSBs
- `i_voice_en`  in  `NUM_VOICES`  per-voice enable
- `o_synth_time`  out  32  sample index, to synth time input
- `o_synth_freq`  out  32  frequency of the voice being rendered
- `o_synth_amp`  out  32  `AMP_UNITY` (1<<15) while rendering, else 0
- `o_synth_trigger`  out  1  one-cycle start pulse to synth
- `i_synth_ready`  in  1  synth sample-done strobe
- `i_synth_sound`  in  32  synth output, signed
- `o_mix`  out  32  signed saturated mix, held between updates
- `o_mix_valid`  out  1  one-cycle pulse when `o_mix` updates
- `o_overrun`  out  1  sticky: a tick arrived while busy

## Operation
- Tick counter counts 0..`SAMPLE_DIV`-1 and wraps. Tick = the cycle the counter equals `SAMPLE_DIV`-1. `o_synth_time` increments by 1 on every tick and wraps at 2^32.
- FSM states: IDLE, SELECT, TRIGGER, WAIT, DONE.
- IDLE, on tick: snapshot `i_voice_en` into `en_q`, clear the accumulator, set `idx`=0, go to SELECT.
- SELECT: search combinationally for the first v ≥ `idx` with `en_q[v]`=1.
  - Found: latch `o_synth_freq` = `i_voice_freq[v]`, set `idx`=v, go to TRIGGER.
  - None found: go to DONE.
- TRIGGER: `o_synth_trigger`=1 for exactly this cycle, then go to WAIT.
- WAIT: hold until `i_synth_ready`=1. Then add sign-extended `i_synth_sound` to the accumulator, set `idx`=`idx`+1, go to SELECT.
- `i_synth_ready` is ignored in every state except WAIT.
- DONE: clamp the accumulator to [-2^31, 2^31-1] into `o_mix`, pulse `o_mix_valid`, go to IDLE.
- The accumulator is 32+$clog2(`NUM_VOICES`)+1 bits signed, so it never wraps internally.
- `o_synth_amp` = `AMP_UNITY` in TRIGGER and WAIT; 0 otherwise.
- Changes to `i_voice_en` after the snapshot do not affect the current sample.
- No voices enabled: `o_mix`=0 and `o_mix_valid` still pulses.
- Tick arrives in any state other than IDLE: the tick is dropped, `o_overrun` is set to 1 and held until reset, `o_synth_time` still increments, and the current sequence continues.
- Synth that never responds: the FSM stays in WAIT, and every later tick sets `o_overrun`. There is no timeout.

## Timing
- Reset (asynchronous): state IDLE, counter 0, `o_synth_time` 0, all other outputs 0, accumulator 0.
- Reset asserted mid-sequence aborts the sequence with no `o_mix_valid` pulse.
- All outputs are registered.
- Tick at cycle T:
  - T+1: SELECT.
  - T+2: TRIGGER, first trigger pulse high.
  - T+3 onward: WAIT.
- Voice cost = 2 + L cycles, where L = cycles from TRIGGER to ready in WAIT (ready in the first WAIT cycle gives L=1).
- `o_mix_valid` is high in the cycle after DONE.
  - No voices enabled: T+3.
- Overrun-free budget: `NUM_VOICES`×(2+L)+3 < `SAMPLE_DIV`.

## Structure
- Package `synth_sched_pkg` holds:
  - `sched_state_t` enum
  - `AMP_UNITY` = 32'd1<<15
  - `DEFAULT_SAMPLE_DIV` = 1042
- Sub-module `mod_sample_ticker`: parameter `SAMPLE_DIV`; outputs `o_tick` and 32-bit `o_time`; same clock and reset.
- Top level holds the FSM, the find-first search, the accumulator and the saturation logic.

## Test plan
Common setup: `SAMPLE_DIV`=32, `NUM_VOICES`=4. Synth model asserts ready 2 cycles after trigger and returns `i_synth_sound` = freq[15:0] sign-extended.
- Reset, all `i_voice_en`=0, run 2 ticks -> no trigger pulses; `o_mix_valid` at T+3 each tick with `o_mix`=0; `o_synth_time`=2.
- `i_voice_en`=4'b0101, freqs 100/–/300/– -> exactly 2 triggers, `o_synth_freq` 100 then 300; `o_mix`=400.
- All 4 enabled, freqs 0x7FFF0000-style values whose sound sum exceeds 2^31-1 (model returns +2^30 each) -> `o_mix`=32'h7FFF_FFFF; a negative set gives 32'h8000_0000.
- Model ready delayed 40 cycles -> `o_overrun`=1 at the next tick, stays 1; `o_synth_time` keeps incrementing; `o_mix_valid` pulses once the sequence completes.
- Toggle `i_voice_en` from 4'b0001 to 4'b1111 during WAIT -> the current sample uses 1 voice; the next sample uses 4.
- Assert `i_rst` during WAIT -> all outputs 0 immediately; no `o_mix_valid`; the stray ready after release is ignored (FSM stays in IDLE).

Source files
------------

// File: rtl/synth_sched_pkg.sv
// Shared types and constants for the voice scheduler and its sample ticker.
package synth_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_TRIGGER,
        S_WAIT,
        S_DONE
    } sched_state_t;

    localparam logic [31:0] AMP_UNITY          = 32'd1 << 15;
    localparam int          DEFAULT_SAMPLE_DIV = 1042;

endpackage

// File: rtl/mod_sample_ticker.sv
// Free-running sample-rate divider: one-cycle tick every SAMPLE_DIV clocks plus a 32-bit sample index.
module mod_sample_ticker
    import synth_sched_pkg::*;
#(
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_tick,
    output logic [31:0] o_time
);

    localparam int CNT_W = $clog2(SAMPLE_DIV + 1);

    logic [CNT_W-1:0] count;

    assign o_tick = (count == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count  <= '0;
            o_time <= '0;
        end else if (o_tick) begin
            count  <= '0;
            o_time <= o_time + 32'd1;
        end else begin
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mod_voice_scheduler.sv
// Time-multiplexes one shared synth core across NUM_VOICES voices and mixes the
// returned samples into one saturated output per sample tick.
module mod_voice_scheduler
    import synth_sched_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_VOICES*32-1:0]   i_voice_freq,
    input  logic [NUM_VOICES-1:0]      i_voice_en,
    output logic [31:0]                o_synth_time,
    output logic [31:0]                o_synth_freq,
    output logic [31:0]                o_synth_amp,
    output logic                       o_synth_trigger,
    input  logic                       i_synth_ready,
    input  logic signed [31:0]         i_synth_sound,
    output logic signed [31:0]         o_mix,
    output logic                       o_mix_valid,
    output logic                       o_overrun
);

    // idx must be able to hold NUM_VOICES (one past the last voice)
    localparam int IDX_W = $clog2(NUM_VOICES) + 1;
    localparam int ACC_W = 32 + $clog2(NUM_VOICES) + 1;

    localparam logic signed [ACC_W-1:0] MIX_MAX = ACC_W'(signed'(32'h7FFF_FFFF));
    localparam logic signed [ACC_W-1:0] MIX_MIN = ACC_W'(signed'(32'h8000_0000));

    function automatic logic signed [31:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > MIX_MAX) return 32'h7FFF_FFFF;
        if (a < MIX_MIN) return 32'h8000_0000;
        return a[31:0];
    endfunction

    sched_state_t            state, state_d;
    logic                    tick;
    logic [NUM_VOICES-1:0]   en_q;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        sel_idx;
    logic                    found;
    logic [31:0]             sel_freq;
    logic signed [ACC_W-1:0] acc;

    mod_sample_ticker #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_ticker (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick),
        .o_time (o_synth_time)
    );

    // Descending scan so the lowest enabled voice at or above idx wins.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        sel_freq = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (en_q[v] && (IDX_W'(v) >= idx)) begin
                found    = 1'b1;
                sel_idx  = IDX_W'(v);
                sel_freq = i_voice_freq[32*v +: 32];
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:    if (tick) state_d = S_SELECT;
            S_SELECT:  state_d = found ? S_TRIGGER : S_DONE;
            S_TRIGGER: state_d = S_WAIT;
            S_WAIT:    if (i_synth_ready) state_d = S_SELECT;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= S_IDLE;
            en_q            <= '0;
            idx             <= '0;
            acc             <= '0;
            o_synth_freq    <= '0;
            o_synth_amp     <= '0;
            o_synth_trigger <= 1'b0;
            o_mix           <= '0;
            o_mix_valid     <= 1'b0;
            o_overrun       <= 1'b0;
        end else begin
            state           <= state_d;
            o_synth_trigger <= (state_d == S_TRIGGER);
            o_synth_amp     <= ((state_d == S_TRIGGER) || (state_d == S_WAIT)) ? AMP_UNITY : 32'd0;
            o_mix_valid     <= (state == S_DONE);
            // A tick outside IDLE is dropped; the running sequence carries on.
            if (tick && (state != S_IDLE)) o_overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        en_q <= i_voice_en;
                        acc  <= '0;
                        idx  <= '0;
                    end
                end
                S_SELECT: begin
                    if (found) begin
                        o_synth_freq <= sel_freq;
                        idx          <= sel_idx;
                    end
                end
                S_WAIT: begin
                    if (i_synth_ready) begin
                        acc <= acc + ACC_W'(i_synth_sound);
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE:  o_mix <= saturate(acc);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_voice_scheduler.sv
// Bench for mod_voice_scheduler: synth responder, per-cycle behavioural model and directed/random stimulus.
module tb_mod_voice_scheduler;

    localparam int NV  = 4;
    localparam int DIV = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NV*32-1:0]   freq;
    logic [NV-1:0]      en;
    logic [31:0]        syn_time, syn_freq, syn_amp;
    logic               syn_trig;
    logic               ready;
    logic signed [31:0] sound;
    logic signed [31:0] mix;
    logic               mix_valid;
    logic               overrun;

    mod_voice_scheduler #(
        .NUM_VOICES (NV),
        .SAMPLE_DIV (DIV)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_voice_freq    (freq),
        .i_voice_en      (en),
        .o_synth_time    (syn_time),
        .o_synth_freq    (syn_freq),
        .o_synth_amp     (syn_amp),
        .o_synth_trigger (syn_trig),
        .i_synth_ready   (ready),
        .i_synth_sound   (sound),
        .o_mix           (mix),
        .o_mix_valid     (mix_valid),
        .o_overrun       (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = -1;
    int dly   = 2;
    int mode  = 0;
    bit spur  = 1'b0;
    int trig_cnt = 0;
    logic [31:0] trig_freq [0:63];

    // Synth sound as a function of the requested frequency.
    function automatic logic [31:0] snd(input logic [31:0] f, input int md);
        if (md == 1) return 32'h4000_0000;
        if (md == 2) return 32'hC000_0000;
        return {{16{f[15]}}, f[15:0]};
    endfunction

    function automatic logic [31:0] sat(input longint s);
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // ---------------- synth responder ----------------
    logic        trig_n = 1'b0;
    logic [31:0] freq_n = '0;

    initial forever begin
        @(negedge clk);
        trig_n = syn_trig;
        freq_n = syn_freq;
    end

    initial begin
        int          cnt;
        logic [31:0] held;
        cnt   = 0;
        held  = '0;
        ready = 1'b0;
        sound = '0;
        forever begin
            @(posedge clk);
            #1;
            if (trig_n) begin
                cnt  = dly;
                held = snd(freq_n, mode);
                trig_freq[trig_cnt % 64] = freq_n;
                trig_cnt++;
            end
            if (cnt > 0) begin
                cnt--;
                ready = (cnt == 0);
                sound = (cnt == 0) ? held : $urandom;
            end else begin
                ready = spur && ($urandom_range(3) == 0);
                sound = $urandom;
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          m_busy = 1'b0;
    int          m_T, m_nv, m_L;
    longint      m_sum;
    logic [31:0] m_f [0:NV-1];
    logic [31:0] exp_mix = '0;
    logic [31:0] last_freq = '0;
    bit          exp_ovr = 1'b0;

    initial forever begin
        bit     e_trig, e_amp, e_valid;
        int     rel, per, base;
        longint s;
        @(negedge clk);
        if (rst) begin
            cyc       = -1;
            m_busy    = 1'b0;
            exp_mix   = '0;
            exp_ovr   = 1'b0;
            last_freq = '0;
            chk("rst_trig", {31'd0, syn_trig}, 32'd0);
            chk("rst_amp", syn_amp, 32'd0);
            chk("rst_valid", {31'd0, mix_valid}, 32'd0);
            chk("rst_mix", mix, 32'd0);
            chk("rst_overrun", {31'd0, overrun}, 32'd0);
            chk("rst_time", syn_time, 32'd0);
            chk("rst_freq", syn_freq, 32'd0);
        end else begin
            cyc++;
            e_trig  = 1'b0;
            e_amp   = 1'b0;
            e_valid = 1'b0;
            if (m_busy) begin
                rel = cyc - m_T;
                per = 2 + m_L;
                for (int k = 0; k < m_nv; k++) begin
                    base = 2 + k * per;
                    if (rel == base) begin
                        e_trig    = 1'b1;
                        last_freq = m_f[k];
                    end
                    if (rel >= base && rel <= base + m_L) e_amp = 1'b1;
                end
                if (rel == 3 + m_nv * per) begin
                    e_valid = 1'b1;
                    exp_mix = sat(m_sum);
                    m_busy  = 1'b0;
                end
            end
            chk("trigger", {31'd0, syn_trig}, {31'd0, e_trig});
            chk("amp", syn_amp, e_amp ? 32'h0000_8000 : 32'd0);
            chk("mix_valid", {31'd0, mix_valid}, {31'd0, e_valid});
            chk("mix", mix, exp_mix);
            chk("freq", syn_freq, last_freq);
            chk("time", syn_time, 32'(cyc / DIV));
            chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
            if (cyc % DIV == DIV - 1) begin
                if (m_busy) begin
                    exp_ovr = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_T    = cyc;
                    m_L    = dly;
                    m_nv   = 0;
                    m_sum  = 0;
                    for (int v = 0; v < NV; v++) begin
                        if (en[v]) begin
                            m_f[m_nv] = freq[32*v +: 32];
                            s         = $signed(snd(freq[32*v +: 32], mode));
                            m_sum    += s;
                            m_nv++;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid(input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (mix_valid !== 1'b1 && k < budget);
        chk(name, {31'd0, mix_valid}, 32'd1);
    endtask

    task automatic wait_trig(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (trig_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, trig_cnt, target);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        rst  = 1'b1;
        en   = '0;
        freq = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // no voices enabled
        t0 = trig_cnt;
        wait_valid(100, "idle_valid1");
        chk("idle_mix1", mix, 32'd0);
        wait_valid(100, "idle_valid2");
        chk("idle_mix2", mix, 32'd0);
        chk("idle_time2", syn_time, 32'd2);
        chk("idle_no_trig", trig_cnt - t0, 32'd0);

        // voices 0 and 2
        drive_edge();
        en   = 4'b0101;
        freq = {$urandom, 32'd300, $urandom, 32'd100};
        t0   = trig_cnt;
        wait_valid(100, "pair_valid");
        chk("pair_mix", mix, 32'd400);
        chk("pair_trigs", trig_cnt - t0, 32'd2);
        chk("pair_freq0", trig_freq[t0 % 64], 32'd100);
        chk("pair_freq1", trig_freq[(t0 + 1) % 64], 32'd300);

        // positive and negative saturation
        drive_edge();
        mode = 1;
        en   = 4'b1111;
        freq = {4{32'h7FFF_0000}};
        wait_valid(100, "satp_valid");
        chk("satp_mix", mix, 32'h7FFF_FFFF);
        drive_edge();
        mode = 2;
        wait_valid(100, "satn_valid");
        chk("satn_mix", mix, 32'h8000_0000);

        // slow synth causes overrun
        drive_edge();
        mode = 0;
        en   = 4'b0001;
        freq = {32'd0, 32'd0, 32'd0, 32'd5};
        dly  = 40;
        wait_valid(200, "slow_valid");
        chk("slow_mix", mix, 32'd5);
        chk("slow_overrun", {31'd0, overrun}, 32'd1);
        drive_edge();
        dly = 2;
        wait_valid(100, "sticky_valid");
        chk("sticky_overrun", {31'd0, overrun}, 32'd1);

        // enable change during WAIT only affects the next sample
        drive_edge();
        en   = 4'b0001;
        freq = {32'd3000, 32'd2000, 32'd1000, 32'd7};
        t0   = trig_cnt;
        wait_trig(t0 + 1, 100, "toggle_first_trig");
        drive_edge();
        en = 4'b1111;
        wait_valid(100, "toggle_valid1");
        chk("toggle_mix1", mix, 32'd7);
        chk("toggle_trigs1", trig_cnt - t0, 32'd1);
        t0 = trig_cnt;
        wait_valid(100, "toggle_valid2");
        chk("toggle_mix2", mix, 32'd6007);
        chk("toggle_trigs2", trig_cnt - t0, 32'd4);

        // reset during WAIT; the late ready must be ignored
        drive_edge();
        en   = 4'b0001;
        freq = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFF6};
        dly  = 10;
        t0   = trig_cnt;
        wait_trig(t0 + 1, 100, "rstw_trig");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        t0 = trig_cnt;
        repeat (15) @(negedge clk);
        chk("rstw_no_retrig", trig_cnt - t0, 32'd0);
        chk("rstw_mix", mix, 32'd0);
        chk("rstw_overrun", {31'd0, overrun}, 32'd0);
        drive_edge();
        dly = 2;
        wait_valid(100, "rstw_valid");
        chk("rstw_mix_after", mix, 32'hFFFF_FFF6);

        // randomized samples with spurious ready strobes
        spur = 1'b1;
        for (int i = 0; i < 25; i++) begin
            drive_edge();
            en   = NV'($urandom);
            freq = {$urandom, $urandom, $urandom, $urandom};
            mode = $urandom_range(2);
            dly  = $urandom_range(1, 4);
            wait_valid(100, "rand_valid");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
